// File: rtl/ram_pkg.sv
// Shared definitions for the RAM read checker: default geometry,
// pass/fail state encoding and saturating 16-bit counter helpers.
package ram_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

  // Counters stop here instead of wrapping back to zero.
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_FAIL = 1'b1
  } chk_state_e;

  // Increment that holds at CNT_MAX.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// RD_LAT-deep delay line carrying {chk, addr, exp} for each issued read,
// so the expected data lines up with the RAM read return.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_chk,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_exp,
  output logic              out_chk,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_exp
);

  logic [RD_LAT-1:0]             chk_q,  chk_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0][DATA_W-1:0] exp_q,  exp_d;

  // Shift: stage 0 takes the new issue, every later stage takes its predecessor.
  always_comb begin
    chk_d     = '0;
    addr_d    = '0;
    exp_d     = '0;
    chk_d[0]  = in_chk;
    addr_d[0] = in_addr;
    exp_d[0]  = in_exp;
    for (int i = 1; i < RD_LAT; i++) begin
      chk_d[i]  = chk_q[i-1];
      addr_d[i] = addr_q[i-1];
      exp_d[i]  = exp_q[i-1];
    end
  end

  // Stage registers; reset clears the valid bits so in-flight reads are dropped.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      chk_q  <= '0;
      addr_q <= '0;
      exp_q  <= '0;
    end else begin
      chk_q  <= chk_d;
      addr_q <= addr_d;
      exp_q  <= exp_d;
    end
  end

  assign out_chk  = chk_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];
  assign out_exp  = exp_q[RD_LAT-1];

endmodule

// File: rtl/ram_rd_check.sv
// Snooping read checker for a single-port RAM: keeps a shadow of every
// written word, compares each read return against the value captured at
// issue, and reports counts, sticky pass/fail and the first mismatch.
module ram_rd_check
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              clr,
  output logic              chk_valid,
  output logic              chk_ok,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              wr_issue;
  logic              rd_issue;
  logic              issue_chk;
  logic              pipe_chk;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_exp;
  logic              cmp_match;

  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;

  chk_state_e        state_q, state_d;
  logic              chk_valid_q, chk_valid_d;
  logic              chk_ok_q, chk_ok_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;

  assign wr_issue = ram_en & ram_we;
  assign rd_issue = ram_en & ~ram_we;

  // Shadow data mirrors every write; its contents need no reset because vld gates use.
  always_ff @(posedge sys_clk) begin
    if (wr_issue) begin
      shadow_q[ram_addr] <= ram_wr_data;
    end
  end

  // Mark a location as known once it has been written.
  always_comb begin
    vld_d = vld_q;
    if (wr_issue) begin
      vld_d[ram_addr] = 1'b1;
    end
  end

  // Valid vector is reset so a fresh run never checks stale shadow contents.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Only reads of written locations are marked for checking; the expected
  // word is frozen here so a later write cannot disturb the pending compare.
  assign issue_chk = rd_issue & vld_q[ram_addr];

  ram_rd_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_chk   (issue_chk),
    .in_addr  (ram_addr),
    .in_exp   (shadow_q[ram_addr]),
    .out_chk  (pipe_chk),
    .out_addr (pipe_addr),
    .out_exp  (pipe_exp)
  );

  assign cmp_match = (ram_rd_data == pipe_exp);

  // Compare, count and run the pass/fail FSM; clr overrides a coincident result.
  always_comb begin
    state_d     = state_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = 1'b0;
    rd_cnt_d    = rd_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    if (clr) begin
      state_d    = ST_PASS;
      rd_cnt_d   = '0;
      err_cnt_d  = '0;
      err_addr_d = '0;
      err_exp_d  = '0;
      err_got_d  = '0;
    end else if (pipe_chk) begin
      chk_valid_d = 1'b1;
      chk_ok_d    = cmp_match;
      rd_cnt_d    = sat_inc(rd_cnt_q);
      if (!cmp_match) begin
        err_cnt_d = sat_inc(err_cnt_q);
        case (state_q)
          ST_PASS: begin
            state_d    = ST_FAIL;
            err_addr_d = pipe_addr;
            err_exp_d  = pipe_exp;
            err_got_d  = ram_rd_data;
          end
          default: begin
            state_d = ST_FAIL;
          end
        endcase
      end
    end
  end

  // Status, counter and capture registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_PASS;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
      rd_cnt_q    <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
    end else begin
      state_q     <= state_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
      rd_cnt_q    <= rd_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
    end
  end

  assign chk_valid = chk_valid_q;
  assign chk_ok    = chk_ok_q;
  assign rd_cnt    = rd_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_flag  = (state_q == ST_FAIL);
  assign err_addr  = err_addr_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: one instance with read latency 1 and one with
// latency 2 share the same snooped bus; a behavioural RAM feeds each its
// read data. Expected compare results are queued at read issue and popped
// when chk_valid pulses.
module tb_ram_rd_check;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       ram_en;
  logic       ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data;
  logic       clr;
  logic [7:0] rd_data1, rd_data2;

  logic        chk_valid1, chk_ok1, err_flag1;
  logic [15:0] rd_cnt1, err_cnt1;
  logic [4:0]  err_addr1;
  logic [7:0]  err_exp1, err_got1;
  logic        chk_valid2, chk_ok2, err_flag2;
  logic [15:0] rd_cnt2, err_cnt2;
  logic [4:0]  err_addr2;
  logic [7:0]  err_exp2, err_got2;

  logic [55:0] st1, st2;
  assign st1 = {chk_valid1, chk_ok1, rd_cnt1, err_cnt1, err_flag1, err_addr1, err_exp1, err_got1};
  assign st2 = {chk_valid2, chk_ok2, rd_cnt2, err_cnt2, err_flag2, err_addr2, err_exp2, err_got2};

  int n_checks = 0;
  int n_errors = 0;
  int pulses1  = 0;
  int pulses2  = 0;
  bit verbose  = 1'b1;
  bit q1[$];
  bit q2[$];
  bit e1, e2;

  logic [7:0] mem [32];
  logic       bad [32];
  logic [7:0] shadow_m [32];
  logic       vld_m [32];
  logic [7:0] ram_q1, ram_q2a, ram_q2b;

  always #5 sys_clk = ~sys_clk;

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(rd_data1), .clr(clr),
    .chk_valid(chk_valid1), .chk_ok(chk_ok1), .rd_cnt(rd_cnt1), .err_cnt(err_cnt1),
    .err_flag(err_flag1), .err_addr(err_addr1), .err_exp(err_exp1), .err_got(err_got1)
  );

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LAT(2)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(rd_data2), .clr(clr),
    .chk_valid(chk_valid2), .chk_ok(chk_ok2), .rd_cnt(rd_cnt2), .err_cnt(err_cnt2),
    .err_flag(err_flag2), .err_addr(err_addr2), .err_exp(err_exp2), .err_got(err_got2)
  );

  // Behavioural read-first RAM; bad[] forces 8'hFF on the return of a read.
  always @(posedge sys_clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
    if (ram_en && !ram_we) begin
      ram_q1  <= bad[ram_addr] ? 8'hFF : mem[ram_addr];
      ram_q2a <= bad[ram_addr] ? 8'hFF : mem[ram_addr];
    end
    ram_q2b <= ram_q2a;
  end
  assign rd_data1 = ram_q1;
  assign rd_data2 = ram_q2b;

  // Scoreboard monitor: pop one expectation per chk_valid pulse.
  always @(negedge sys_clk) begin
    n_checks += 2;
    if (!chk_valid1 && chk_ok1 !== 1'b0) begin
      n_errors++; $display("FAIL ok_qual dut1 chk_ok=%b while chk_valid=0, required 0", chk_ok1);
    end
    if (!chk_valid2 && chk_ok2 !== 1'b0) begin
      n_errors++; $display("FAIL ok_qual dut2 chk_ok=%b while chk_valid=0, required 0", chk_ok2);
    end
    if (chk_valid1 === 1'b1) begin
      pulses1++; n_checks++;
      if (q1.size() == 0) begin
        n_errors++; $display("FAIL pulse dut1 got unexpected chk_valid, required none");
      end else begin
        e1 = q1.pop_front();
        if (chk_ok1 !== e1) begin
          n_errors++; $display("FAIL chk_ok dut1 got=%b exp=%b", chk_ok1, e1);
        end
      end
      if (verbose) $display("txn dut1 chk_ok=%b rd_cnt=%0d err_cnt=%0d", chk_ok1, rd_cnt1, err_cnt1);
    end
    if (chk_valid2 === 1'b1) begin
      pulses2++; n_checks++;
      if (q2.size() == 0) begin
        n_errors++; $display("FAIL pulse dut2 got unexpected chk_valid, required none");
      end else begin
        e2 = q2.pop_front();
        if (chk_ok2 !== e2) begin
          n_errors++; $display("FAIL chk_ok dut2 got=%b exp=%b", chk_ok2, e2);
        end
      end
      if (verbose) $display("txn dut2 chk_ok=%b rd_cnt=%0d err_cnt=%0d", chk_ok2, rd_cnt2, err_cnt2);
    end
  end

  // Drive one bus cycle at the falling edge and queue the expected result of a read.
  task automatic cyc(input logic en, input logic we, input logic [4:0] addr,
                     input logic [7:0] wd, input logic c, input bit p1, input bit p2);
    logic [7:0] got;
    @(negedge sys_clk);
    ram_en = en; ram_we = we; ram_addr = addr; ram_wr_data = wd; clr = c;
    if (en && !we && vld_m[addr]) begin
      got = bad[addr] ? 8'hFF : shadow_m[addr];
      if (p1) q1.push_back(got == shadow_m[addr]);
      if (p2) q2.push_back(got == shadow_m[addr]);
    end
    if (en && we) begin
      shadow_m[addr] = wd;
      vld_m[addr]    = 1'b1;
    end
  endtask

  task automatic rd(input logic [4:0] a);
    cyc(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic do_clr();
    cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks += 2;
    if (st1 !== 56'd0) begin n_errors++; $display("FAIL reset dut1 got=%h exp=0", st1); end
    if (st2 !== 56'd0) begin n_errors++; $display("FAIL reset dut2 got=%h exp=0", st2); end
    sys_rst = 1'b0;
  endtask

  task automatic test_unwritten();
    int p1, p2;
    p1 = pulses1; p2 = pulses2;
    rd(5'd3);
    idle(4);
    n_checks += 3;
    if (st1 !== 56'd0) begin n_errors++; $display("FAIL unwritten dut1 got=%h exp=0", st1); end
    if (st2 !== 56'd0) begin n_errors++; $display("FAIL unwritten dut2 got=%h exp=0", st2); end
    if (pulses1 != p1 || pulses2 != p2) begin
      n_errors++; $display("FAIL unwritten pulses got=%0d/%0d exp=%0d/%0d", pulses1, pulses2, p1, p2);
    end
  endtask

  task automatic test_write_read();
    int p1, p2;
    for (int a = 0; a < 32; a++) wr(5'(a), 8'(a));
    p1 = pulses1; p2 = pulses2;
    for (int a = 0; a < 32; a++) rd(5'(a));
    idle(4);
    n_checks += 4;
    if (st1 !== {2'b00, 16'd32, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL wr_rd dut1 got=%h exp rd_cnt=32 clean", st1);
    end
    if (st2 !== {2'b00, 16'd32, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL wr_rd dut2 got=%h exp rd_cnt=32 clean", st2);
    end
    if (pulses1 - p1 != 32 || pulses2 - p2 != 32) begin
      n_errors++; $display("FAIL wr_rd pulses got=%0d/%0d exp=32/32", pulses1 - p1, pulses2 - p2);
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_errors++; $display("FAIL wr_rd missing pulses got=%0d/%0d pending exp=0", q1.size(), q2.size());
    end
  endtask

  task automatic test_errors();
    do_clr();
    bad[5] = 1'b1;
    bad[9] = 1'b1;
    for (int a = 0; a < 32; a++) rd(5'(a));
    idle(4);
    bad[5] = 1'b0;
    bad[9] = 1'b0;
    n_checks += 3;
    if (st1 !== {2'b00, 16'd32, 16'd2, 1'b1, 5'd5, 8'h05, 8'hFF}) begin
      n_errors++; $display("FAIL errors dut1 got=%h exp cnt=32/2 flag addr=5 exp=05 got=FF", st1);
    end
    if (st2 !== {2'b00, 16'd32, 16'd2, 1'b1, 5'd5, 8'h05, 8'hFF}) begin
      n_errors++; $display("FAIL errors dut2 got=%h exp cnt=32/2 flag addr=5 exp=05 got=FF", st2);
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_errors++; $display("FAIL errors missing pulses got=%0d/%0d pending exp=0", q1.size(), q2.size());
    end
  endtask

  task automatic test_stale_write();
    do_clr();
    rd(5'd7);
    wr(5'd7, 8'hAA);
    idle(4);
    n_checks += 2;
    if (st1 !== {2'b00, 16'd1, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL stale dut1 got=%h exp rd_cnt=1 no error", st1);
    end
    if (st2 !== {2'b00, 16'd1, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL stale dut2 got=%h exp rd_cnt=1 no error", st2);
    end
    wr(5'd7, 8'h07);
  endtask

  task automatic test_clr_drop();
    bad[4] = 1'b1;
    cyc(1'b1, 1'b0, 5'd4, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    bad[4] = 1'b0;
    idle(4);
    n_checks += 2;
    if (st1 !== 56'd0) begin n_errors++; $display("FAIL clr_drop dut1 got=%h exp=0", st1); end
    if (st2 !== 56'd0) begin n_errors++; $display("FAIL clr_drop dut2 got=%h exp=0", st2); end
    for (int a = 0; a < 32; a++) rd(5'(a));
    idle(4);
    n_checks += 2;
    if (st1 !== {2'b00, 16'd32, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL clr_shadow dut1 got=%h exp rd_cnt=32 clean", st1);
    end
    if (st2 !== {2'b00, 16'd32, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL clr_shadow dut2 got=%h exp rd_cnt=32 clean", st2);
    end
  endtask

  task automatic test_saturation();
    do_clr();
    verbose = 1'b0;
    repeat (65540) rd(5'd0);
    idle(4);
    verbose = 1'b1;
    n_checks += 2;
    if (st1 !== {2'b00, 16'hFFFF, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL saturate dut1 got=%h exp rd_cnt=FFFF", st1);
    end
    if (st2 !== {2'b00, 16'hFFFF, 16'd0, 1'b0, 5'd0, 8'h00, 8'h00}) begin
      n_errors++; $display("FAIL saturate dut2 got=%h exp rd_cnt=FFFF", st2);
    end
  endtask

  task automatic test_reset_inflight();
    int p1, p2;
    // Read 1 completes on dut1 before reset; both reads are still in flight on dut2.
    cyc(1'b1, 1'b0, 5'd1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    ram_en = 1'b0;
    #2 sys_rst = 1'b1;
    #1;
    n_checks += 2;
    if (st1 !== 56'd0) begin n_errors++; $display("FAIL rst_inflight dut1 got=%h exp=0", st1); end
    if (st2 !== 56'd0) begin n_errors++; $display("FAIL rst_inflight dut2 got=%h exp=0", st2); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int a = 0; a < 32; a++) vld_m[a] = 1'b0;
    p1 = pulses1; p2 = pulses2;
    idle(5);
    n_checks += 4;
    if (pulses1 != p1 || pulses2 != p2) begin
      n_errors++; $display("FAIL rst_inflight pulses got=%0d/%0d exp=0/0", pulses1 - p1, pulses2 - p2);
    end
    if (q1.size() != 0 || q2.size() != 0) begin
      n_errors++; $display("FAIL rst_inflight pending got=%0d/%0d exp=0", q1.size(), q2.size());
    end
    if (st1 !== 56'd0) begin n_errors++; $display("FAIL rst_after dut1 got=%h exp=0", st1); end
    if (st2 !== 56'd0) begin n_errors++; $display("FAIL rst_after dut2 got=%h exp=0", st2); end
  endtask

  initial begin
    sys_rst = 1'b1;
    ram_en = 1'b0; ram_we = 1'b0; ram_addr = '0; ram_wr_data = '0; clr = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bad[a] = 1'b0;
      vld_m[a] = 1'b0;
      shadow_m[a] = 8'h00;
    end
    test_reset();
    test_unwritten();
    test_write_read();
    test_errors();
    test_stale_write();
    test_clr_drop();
    test_saturation();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_rd_check.md
# ram_rd_check

Checker stage directly downstream of the single-port block RAM port (32 × 8) driven by the RAM read/write sequencer. It snoops the RAM control/write bus and the RAM read-data output. It keeps a shadow copy of every written location and compares each read return against it after the RAM read latency. It reports read/error counts, a pass/fail status and a first-error capture for board LEDs/ILA or the testbench.

## Interface
Parameters:
- ADDR_W, 5, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM data width
- RD_LAT, 1, RAM read latency in clocks; legal values 1 or 2

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst  in  1  reset, asynchronous, active-high
- ram_en  in  1  RAM enable (snooped)
- ram_we  in  1  RAM write enable (snooped)
- ram_addr  in  ADDR_W  RAM address (snooped)
- ram_wr_data  in  DATA_W  RAM write data (snooped)
- ram_rd_data  in  DATA_W  RAM read data output
- clr  in  1  synchronous clear of counters, status and capture; shadow kept
- chk_valid  out  1  one-cycle pulse: a compare completed this cycle
- chk_ok  out  1  qualifies chk_valid: 1 = match
- rd_cnt  out  16  number of checked reads, saturating
- err_cnt  out  16  number of mismatches, saturating
- err_flag  out  1  sticky fail status (state FAIL)
- err_addr  out  ADDR_W  address of first mismatch
- err_exp  out  DATA_W  expected data of first mismatch
- err_got  out  DATA_W  received data of first mismatch

## Operation
- Write issue (ram_en=1, ram_we=1 at an edge): shadow[ram_addr] <= ram_wr_data; vld[ram_addr] <= 1.
- Read issue (ram_en=1, ram_we=0): push {chk = vld[addr], addr, exp = shadow[addr]} into an RD_LAT-deep delay pipeline. Expected data is frozen at issue. A later write to the same address does not alter the pending compare.
- Read of a never-written location (vld=0): travels the pipeline, produces no chk_valid and no count change.
- Pipeline exit with chk=1: chk_valid=1, chk_ok=(ram_rd_data==exp); rd_cnt+1. On mismatch, err_cnt+1.
- Counters saturate at 16'hFFFF; they never wrap.
- Status FSM: PASS -> FAIL on the first mismatch; the entry mismatch loads err_addr/err_exp/err_got. FAIL is held (later mismatches only count); FAIL -> PASS only on clr or reset.
- clr wins over a coincident compare: that result is dropped (no pulse, no count, no capture). The pipeline contents and shadow/vld are kept.
- ram_en=0: no action; pipeline still advances (bubble).

## Timing
- Read issued at edge k: ram_rd_data is sampled and compared at edge k+RD_LAT. chk_valid, chk_ok, counters and capture are visible after that edge.
- Back-to-back reads give one compare per cycle; throughput 1/clk.
- Reset values: chk_valid=0, chk_ok=0, rd_cnt=0, err_cnt=0, err_flag=0, err_addr=0, err_exp=0, err_got=0, FSM=PASS, all vld=0, pipeline valid bits=0. Shadow data is don't-care.
- Reset asserted mid-operation flushes in-flight reads; no chk_valid pulse for them after release.
- chk_ok is 0 whenever chk_valid is 0.

## Structure
- Shared package (ram_pkg): ADDR_W/DATA_W defaults, the FSM state encoding (PASS, FAIL) and the 16-bit counter saturation constant.
- One natural sub-module: ram_rd_pipe, the RD_LAT-deep delay line carrying {chk, addr, exp}.
- Shadow: 2^ADDR_W × DATA_W registers plus a 2^ADDR_W vld vector. Registers, not inferred RAM, so that vld clears on reset.

## Test plan
- Write addr 0..31 with data=addr, then read 0..31 (RD_LAT=1) -> 32 chk_valid pulses, all chk_ok=1; rd_cnt=32, err_cnt=0, err_flag=0.
- Same, but force ram_rd_data=8'hFF on the read of addr 5 -> err_cnt=1, err_flag=1, err_addr=5, err_exp=8'h05, err_got=8'hFF. A second mismatch at addr 9 -> err_cnt=2 and capture still shows addr 5.
- After reset, read addr 3 before any write -> no chk_valid, rd_cnt=0.
- Read addr 7 (shadow 8'h07), then write 8'hAA to addr 7 on the next cycle with RD_LAT=2 -> compare expects 8'h07, chk_ok=1 when RAM returns 8'h07.
- Assert clr on the cycle a mismatch compares -> no pulse; counters, err_flag and capture all 0; shadow intact (subsequent reads of 0..31 pass).
- Preload rd_cnt via 65,540 reads -> rd_cnt stays 16'hFFFF. Assert sys_rst with two reads in flight -> all outputs reset and no pulse after release.
